// File: rtl/jtag_shift_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : jtag_shift_engine_if
// Brief    : Command/response bundle between the register bank and the JTAG
//            shift engine. cmd_trst exists only when JTAG_TRST_EN is defined.
// Revision : 1.0
// ============================================================================
interface jtag_shift_engine_if #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = $clog2(DATA_W + 1),
  parameter int DIV_W  = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] cmd_tms;
  logic [DATA_W-1:0] cmd_tdi;
  logic [DIV_W-1:0]  cmd_div;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_tdo;
  logic              busy;
`ifdef JTAG_TRST_EN
  logic              cmd_trst;

  modport master (
    output cmd_valid, cmd_len, cmd_tms, cmd_tdi, cmd_div, cmd_trst, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_tdo, busy
  );
  modport slave (
    input  cmd_valid, cmd_len, cmd_tms, cmd_tdi, cmd_div, cmd_trst, rsp_ready,
    output cmd_ready, rsp_valid, rsp_tdo, busy
  );
`else
  modport master (
    output cmd_valid, cmd_len, cmd_tms, cmd_tdi, cmd_div, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_tdo, busy
  );
  modport slave (
    input  cmd_valid, cmd_len, cmd_tms, cmd_tdi, cmd_div, rsp_ready,
    output cmd_ready, rsp_valid, rsp_tdo, busy
  );
`endif
endinterface
`default_nettype wire

// File: rtl/jtag_shift_engine.sv
`default_nettype none
// ============================================================================
// Module   : jtag_shift_engine
// Brief    : JTAG master; shifts up to DATA_W TMS/TDI bits LSB first with a
//            programmable TCK half-period and captures TDO into a response.
//            Optional TAP reset pulse enabled by defining JTAG_TRST_EN.
// Revision : 1.0
// ============================================================================
module jtag_shift_engine #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = $clog2(DATA_W + 1),
  parameter int DIV_W  = 8
) (
  input  wire                clk,
  input  wire                rst_n,
  jtag_shift_engine_if.slave bus,
`ifdef JTAG_TRST_EN
  output logic               trst_n,
`endif
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  wire                tdo
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOW  = 3'd1;
  localparam logic [2:0] S_HIGH = 3'd2;
  localparam logic [2:0] S_RESP = 3'd3;
`ifdef JTAG_TRST_EN
  localparam logic [2:0] S_TRST = 3'd4;
`endif

  localparam logic [LEN_W-1:0] c_len_max = LEN_W'(DATA_W);

  logic [2:0]        r_state;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_tms_bits;
  logic [DATA_W-1:0] r_tdi_bits;
  logic [DATA_W-1:0] r_cap;
  logic [DIV_W-1:0]  r_div;
  // One extra bit so the TRST phase (2*(div+1) cycles) never wraps at max div.
  logic [DIV_W:0]    r_cnt;
  logic              r_tck;
  logic              r_tms;
  logic              r_tdi;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_tdo;
  logic              r_busy;
  logic              r_cmd_ready;
`ifdef JTAG_TRST_EN
  logic              r_trst_n;
`endif

  logic              w_accept;
  logic [LEN_W-1:0]  w_len_clamped;
  logic              w_phase_end;
  logic [LEN_W-1:0]  w_idx_next;
  logic [IDX_W-1:0]  w_idx_bit;
  logic [IDX_W-1:0]  w_idx_next_bit;
  logic              w_sample;
  logic [DATA_W-1:0] w_cap_next;

  assign w_accept       = bus.cmd_valid & r_cmd_ready;
  assign w_len_clamped  = (bus.cmd_len > c_len_max) ? c_len_max : bus.cmd_len;
  assign w_phase_end    = (r_cnt == {1'b0, r_div});
  assign w_idx_next     = r_idx + 1'b1;
  assign w_idx_bit      = r_idx[IDX_W-1:0];
  assign w_idx_next_bit = w_idx_next[IDX_W-1:0];
  assign w_sample       = (r_state == S_HIGH) && (r_cnt == '0);

  // TDO is taken at the end of the first HIGH cycle; merged combinationally so
  // a div=0 phase (sample and phase end on the same edge) still lands in rsp.
  always_comb begin
    w_cap_next = r_cap;
    if (w_sample) begin
      w_cap_next[w_idx_bit] = tdo;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_idx       <= '0;
      r_tms_bits  <= '0;
      r_tdi_bits  <= '0;
      r_cap       <= '0;
      r_div       <= '0;
      r_cnt       <= '0;
      r_tck       <= 1'b0;
      r_tms       <= 1'b1;
      r_tdi       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_tdo   <= '0;
      r_busy      <= 1'b0;
      r_cmd_ready <= 1'b0;
`ifdef JTAG_TRST_EN
      r_trst_n    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
`ifdef JTAG_TRST_EN
          r_trst_n    <= 1'b1;
`endif
          if (w_accept) begin
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_len       <= w_len_clamped;
            r_tms_bits  <= bus.cmd_tms;
            r_tdi_bits  <= bus.cmd_tdi;
            r_div       <= bus.cmd_div;
            r_idx       <= '0;
            r_cap       <= '0;
            r_cnt       <= '0;
`ifdef JTAG_TRST_EN
            if (bus.cmd_trst) begin
              r_state  <= S_TRST;
              r_trst_n <= 1'b0;
              r_tck    <= 1'b0;
              r_tms    <= 1'b1;
            end else
`endif
            if (w_len_clamped == '0) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_tdo   <= '0;
            end else begin
              r_state <= S_LOW;
              r_tck   <= 1'b0;
              r_tms   <= bus.cmd_tms[0];
              r_tdi   <= bus.cmd_tdi[0];
            end
          end
        end

        S_LOW: begin
          if (w_phase_end) begin
            r_cnt   <= '0;
            r_state <= S_HIGH;
            r_tck   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_HIGH: begin
          if (w_sample) begin
            r_cap <= w_cap_next;
          end
          if (w_phase_end) begin
            r_cnt <= '0;
            r_idx <= w_idx_next;
            r_tck <= 1'b0;
            if (w_idx_next == r_len) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_tdo   <= w_cap_next;
            end else begin
              r_state <= S_LOW;
              r_tms   <= r_tms_bits[w_idx_next_bit];
              r_tdi   <= r_tdi_bits[w_idx_next_bit];
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

`ifdef JTAG_TRST_EN
        S_TRST: begin
          if (r_cnt == {r_div, 1'b1}) begin
            r_cnt       <= '0;
            r_trst_n    <= 1'b1;
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_tdo   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif

        default: begin
          r_state     <= S_IDLE;
          r_tck       <= 1'b0;
          r_tms       <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_tdo   = r_rsp_tdo;
  assign bus.busy      = r_busy;
  assign tck           = r_tck;
  assign tms           = r_tms;
  assign tdi           = r_tdi;
`ifdef JTAG_TRST_EN
  assign trst_n        = r_trst_n;
`endif

endmodule
`default_nettype wire

// File: tb/tb_jtag_shift_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtag_shift_engine
// Brief    : Scoreboard bench for jtag_shift_engine with a simple TAP TDO model.
// Revision : 1.0
// ============================================================================
module tb_jtag_shift_engine;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 6;
  localparam int DIV_W  = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic tck, tms, tdi, tdo;
`ifdef JTAG_TRST_EN
  logic trst_n;
`endif

  always #5 clk = ~clk;

  jtag_shift_engine_if #(.DATA_W(DATA_W), .LEN_W(LEN_W), .DIV_W(DIV_W)) bus ();

  jtag_shift_engine #(.DATA_W(DATA_W), .LEN_W(LEN_W), .DIV_W(DIV_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
`ifdef JTAG_TRST_EN
    .trst_n (trst_n),
`endif
    .tck    (tck),
    .tms    (tms),
    .tdi    (tdi),
    .tdo    (tdo)
  );

  typedef struct {
    logic [31:0] tdo;
    logic [31:0] tms;
    logic [31:0] tdi;
    int          lat;
    int          pulses;
    int          div;
    int          hold;
    int          trst_cycles;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_pass   = 0;
  int   n_total  = 0;
  bit   mon_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
  endtask

  // TAP model: TDO advances on each TCK falling edge, LSB of tdo_word first.
  int          tdo_idx  = 0;
  int          tdo_base = 0;
  int          tdo_k;
  logic [31:0] tdo_word = 32'h0;
  always @(negedge tck) tdo_idx <= tdo_idx + 1;
  assign tdo_k = tdo_idx - tdo_base;
  assign tdo   = (tdo_k >= 0 && tdo_k < 32) ? tdo_word[tdo_k[4:0]] : 1'b0;

  // Pin activity per command, cleared on the accepting edge.
  int          cyc      = 0;
  int          pulses   = 0;
  int          hi_cur   = 0;
  int          hi_min   = 1000;
  int          hi_max   = 0;
  int          trst_lo  = 0;
  logic [31:0] tms_seen = 32'h0;
  logic [31:0] tdi_seen = 32'h0;
  logic        tck_prev = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && bus.cmd_valid && bus.cmd_ready) begin
      pulses   <= 0;
      hi_cur   <= 0;
      hi_min   <= 1000;
      hi_max   <= 0;
      trst_lo  <= 0;
      tms_seen <= 32'h0;
      tdi_seen <= 32'h0;
    end else begin
      if (tck && !tck_prev) begin
        if (pulses < 32) begin
          tms_seen[pulses[4:0]] <= tms;
          tdi_seen[pulses[4:0]] <= tdi;
        end
        pulses <= pulses + 1;
      end
      if (tck) begin
        hi_cur <= hi_cur + 1;
      end else if (tck_prev) begin
        if (hi_cur < hi_min) hi_min <= hi_cur;
        if (hi_cur > hi_max) hi_max <= hi_cur;
        hi_cur <= 0;
      end
`ifdef JTAG_TRST_EN
      if (!trst_n) trst_lo <= trst_lo + 1;
`endif
    end
    tck_prev <= tck;
  end

  // Monitor: pops an expectation whenever a response appears.
  initial begin
    exp_t        e;
    logic [31:0] held;
    bus.rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.rsp_valid) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 rsp_tdo=0x%08h, required no response", bus.rsp_tdo);
          bus.rsp_ready = 1'b1;
          @(negedge clk);
          bus.rsp_ready = 1'b0;
        end else begin
          mon_busy = 1'b1;
          e = sb.pop_front();
          // rsp_valid set on edge acc+lat (first visible one edge later).
          check("rsp_latency", cyc - e.acc, e.lat);
          check("rsp_tdo", bus.rsp_tdo, e.tdo);
          held = bus.rsp_tdo;
          for (int i = 0; i < e.hold; i++) begin
            @(negedge clk);
            check("bp_flags{valid,ready,tck,busy}",
                  {28'h0, bus.rsp_valid, bus.cmd_ready, tck, bus.busy}, 32'h9);
            check("bp_rsp_tdo_stable", bus.rsp_tdo, held);
          end
          bus.rsp_ready = 1'b1;
          @(negedge clk);
          bus.rsp_ready = 1'b0;
          check("post_hs{valid,ready,busy}",
                {29'h0, bus.rsp_valid, bus.cmd_ready, bus.busy}, 32'h2);
          check("tck_pulses", pulses, e.pulses);
          check("tms_sequence", tms_seen, e.tms);
          check("tdi_sequence", tdi_seen, e.tdi);
          if (e.pulses > 0) begin
            check("tck_high_min", hi_min, e.div + 1);
            check("tck_high_max", hi_max, e.div + 1);
          end
`ifdef JTAG_TRST_EN
          check("trst_low_cycles", trst_lo, e.trst_cycles);
`endif
          mon_busy = 1'b0;
        end
      end
    end
  end

  // Presents a command, waits for acceptance, pushes the expectation.
  task automatic issue(input int len, input logic [31:0] tms_v, input logic [31:0] tdi_v,
                       input int div, input logic [31:0] word, input logic [31:0] exp_tdo,
                       input int hold, input bit trst, input bit expect_rsp);
    exp_t        e;
    int          n;
    logic [31:0] mask;
    bus.cmd_len   = LEN_W'(len);
    bus.cmd_tms   = tms_v;
    bus.cmd_tdi   = tdi_v;
    bus.cmd_div   = DIV_W'(div);
`ifdef JTAG_TRST_EN
    bus.cmd_trst  = trst;
`endif
    bus.cmd_valid = 1'b1;
    for (int t = 0; t < 3000 && !bus.cmd_ready; t++) @(negedge clk);
    if (!bus.cmd_ready) begin
      n_total++;
      $display("FAIL accept_timeout: got cmd_ready=0 after 3000 cycles, required 1");
      bus.cmd_valid = 1'b0;
      return;
    end
    tdo_word = word;
    tdo_base = tdo_idx;
    n = trst ? 0 : ((len > 32) ? 32 : len);
    mask = (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    e.tdo         = exp_tdo;
    e.tms         = tms_v & mask;
    e.tdi         = tdi_v & mask;
    e.pulses      = n;
    e.lat         = trst ? 2 * (div + 1) : n * 2 * (div + 1);
    e.div         = div;
    e.hold        = hold;
    e.trst_cycles = trst ? 2 * (div + 1) : 0;
    e.acc         = cyc + 1;
    if (expect_rsp) sb.push_back(e);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 6000 && (sb.size() != 0 || mon_busy); t++) @(negedge clk);
    if (sb.size() != 0 || mon_busy) begin
      n_total++;
      $display("FAIL drain_timeout: got %0d pending responses, required 0", sb.size());
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_len   = '0;
    bus.cmd_tms   = '0;
    bus.cmd_tdi   = '0;
    bus.cmd_div   = '0;
`ifdef JTAG_TRST_EN
    bus.cmd_trst  = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset{tck,tms,tdi,valid,ready,busy}",
          {26'h0, tck, tms, tdi, bus.rsp_valid, bus.cmd_ready, bus.busy}, 32'h10);
    check("reset_rsp_tdo", bus.rsp_tdo, 32'h0);
`ifdef JTAG_TRST_EN
    check("reset_trst_n", trst_n, 32'h0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    check("cmd_ready_after_reset", bus.cmd_ready, 32'h1);

    // len  tms            tdi            div  tdo_word       exp_tdo        hold trst rsp
    issue(6,  32'h0000_001F, 32'h0000_0000, 0,   32'h0000_0000, 32'h0000_0000, 0,  0, 1);
    issue(32, 32'h8000_0000, 32'hA5A5_0F0F, 3,   32'h4BA0_0477, 32'h4BA0_0477, 2,  0, 1);
    issue(0,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,   32'hFFFF_FFFF, 32'h0000_0000, 0,  0, 1);
    issue(40, 32'hFFFF_0000, 32'h1234_5678, 0,   32'hDEAD_BEEF, 32'hDEAD_BEEF, 0,  0, 1);
    issue(3,  32'h0000_0005, 32'h0000_0002, 1,   32'hFFFF_FFFF, 32'h0000_0007, 0,  0, 1);
    issue(4,  32'h0000_0000, 32'h0000_000F, 0,   32'h0000_000A, 32'h0000_000A, 10, 0, 1);
    issue(2,  32'h0000_0003, 32'h0000_0001, 0,   32'h0000_0001, 32'h0000_0001, 0,  0, 1);
    issue(1,  32'h0000_0000, 32'h0000_0001, 255, 32'h0000_0001, 32'h0000_0001, 0,  0, 1);
`ifdef JTAG_TRST_EN
    issue(5,  32'h0000_001F, 32'h0000_001F, 1,   32'hFFFF_FFFF, 32'h0000_0000, 0,  1, 1);
`endif
    drain();

    // Reset in the middle of a high TCK phase of a 16-bit shift.
    issue(16, 32'h0000_FFFF, 32'h0000_AAAA, 2,   32'hFFFF_FFFF, 32'h0000_0000, 0,  0, 0);
    for (int t = 0; t < 300 && pulses < 5; t++) @(negedge clk);
    check("midshift_pulses_reached", (pulses >= 5) ? 32'h1 : 32'h0, 32'h1);
    check("midshift_tck_high_before_reset", tck, 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midshift_reset{tck,tms,valid,ready,busy}",
          {27'h0, tck, tms, bus.rsp_valid, bus.cmd_ready, bus.busy}, 32'h8);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("cmd_ready_after_midshift_reset", bus.cmd_ready, 32'h1);
    repeat (20) @(negedge clk);
    check("no_tck_after_midshift_reset", pulses, 32'd5);
    issue(2,  32'h0000_0000, 32'h0000_0002, 0,   32'h0000_0002, 32'h0000_0002, 0,  0, 1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
